// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every non-clock signal between the decode stage and its neighbours.
//   Fetch side     : if_valid, if_instr -> stage ; if_ready <- stage
//   Writeback side : wb_en, wb_addr, wb_data -> stage
//   Execute side   : ex_ready -> stage ; ex_valid, ex_alu_ctrl, ex_in1,
//                    ex_in2, ex_rd <- stage
//   Status         : illegal_op <- stage (sticky)
// The stage connects through the slave modport. The environment that drives
// fetch, writeback and EX uses the master modport.
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DW = 32
);
  logic          if_valid;
  logic [18:0]   if_instr;
  logic          if_ready;
  logic          wb_en;
  logic [3:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_ready;
  logic          ex_valid;
  logic [4:0]    ex_alu_ctrl;
  logic [DW-1:0] ex_in1;
  logic [DW-1:0] ex_in2;
  logic [3:0]    ex_rd;
  logic          illegal_op;

  modport slave (
    input  if_valid, if_instr, wb_en, wb_addr, wb_data, ex_ready,
    output if_ready, ex_valid, ex_alu_ctrl, ex_in1, ex_in2, ex_rd, illegal_op
  );

  modport master (
    output if_valid, if_instr, wb_en, wb_addr, wb_data, ex_ready,
    input  if_ready, ex_valid, ex_alu_ctrl, ex_in1, ex_in2, ex_rd, illegal_op
  );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode stage of the 19-bit CPU. Decodes one instruction per cycle, reads a
// 16x32 register file (with writeback bypass), and loads the ID/EX register
// feeding the ALU. A busy-bit scoreboard stalls fetch on read-after-write
// hazards until the producer writes back.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : id_ex_stage_if.slave (fetch handshake, writeback port, EX outputs)
// Instruction: [18:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [1:0] unused.
// IMMED carries imm10 in [9:0].
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_if.slave   bus
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_MUL   = 5'd2,  OP_DIV = 5'd3,
    OP_INC   = 5'd4,  OP_DEC   = 5'd5,  OP_AND   = 5'd6,  OP_OR  = 5'd7,
    OP_XOR   = 5'd8,  OP_NOT   = 5'd9,  OP_ENCRY = 5'd10, OP_DECRY = 5'd11,
    OP_IMMED = 5'd12
  } opcode_e;

  // Architectural and pipeline state
  logic [DW-1:0]    r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_ex_valid;
  logic [4:0]       r_ex_alu_ctrl;
  logic [DW-1:0]    r_ex_in1;
  logic [DW-1:0]    r_ex_in2;
  logic [3:0]       r_ex_rd;
  logic             r_illegal_op;

  // Decode
  opcode_e       w_opcode;
  logic [3:0]    w_rd, w_rs1, w_rs2;
  logic [9:0]    w_imm10;
  logic          w_legal, w_is_immed, w_use_rs1, w_use_rs2;
  logic          w_byp1, w_byp2;
  logic [DW-1:0] w_rs1_val, w_rs2_val, w_in1, w_in2;
  logic          w_hazard, w_if_ready, w_accept;

  assign w_opcode = opcode_e'(bus.if_instr[18:14]);
  assign w_rd     = bus.if_instr[13:10];
  assign w_rs1    = bus.if_instr[9:6];
  assign w_rs2    = bus.if_instr[5:2];
  assign w_imm10  = bus.if_instr[9:0];

  assign w_legal    = (bus.if_instr[18:14] <= 5'd12);
  assign w_is_immed = (w_opcode == OP_IMMED);
  // Every legal op except IMMED reads rs1; only the binary ops read rs2.
  // Illegal opcodes read nothing, so they can never cause a hazard stall.
  assign w_use_rs1  = w_legal && !w_is_immed;
  assign w_use_rs2  = w_opcode inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                                       OP_AND, OP_OR, OP_XOR};

  // A writeback in the same cycle forwards straight into decode, which is
  // what lets a dependent op issue in the very cycle its producer retires.
  assign w_byp1    = bus.wb_en && (bus.wb_addr == w_rs1);
  assign w_byp2    = bus.wb_en && (bus.wb_addr == w_rs2);
  assign w_rs1_val = w_byp1 ? bus.wb_data : r_regs[w_rs1];
  assign w_rs2_val = w_byp2 ? bus.wb_data : r_regs[w_rs2];

  assign w_in1 = w_is_immed ? '0 : w_rs1_val;
  assign w_in2 = w_is_immed ? {{(DW-10){1'b0}}, w_imm10}
               : (w_use_rs2 ? w_rs2_val : '0);

  assign w_hazard   = (w_use_rs1 && r_busy[w_rs1] && !w_byp1) ||
                      (w_use_rs2 && r_busy[w_rs2] && !w_byp2);
  assign w_if_ready = !w_hazard && (!r_ex_valid || bus.ex_ready);
  assign w_accept   = bus.if_valid && w_if_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is explicitly cleared on reset, so it is
      // built from flops rather than an inferred RAM macro.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy        <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_alu_ctrl <= '0;
      r_ex_in1      <= '0;
      r_ex_in2      <= '0;
      r_ex_rd       <= '0;
      r_illegal_op  <= 1'b0;
    end else begin
      if (bus.wb_en) begin
        r_regs[bus.wb_addr] <= bus.wb_data;
        r_busy[bus.wb_addr] <= 1'b0;
      end

      if (w_accept) begin
        if (w_legal) begin
          // NOTE: this set is written after the writeback clear above; the
          // later non-blocking assignment wins, so set beats clear.
          r_busy[w_rd]  <= 1'b1;
          r_ex_valid    <= 1'b1;
          r_ex_alu_ctrl <= bus.if_instr[18:14];
          r_ex_in1      <= w_in1;
          r_ex_in2      <= w_in2;
          r_ex_rd       <= w_rd;
        end else begin
          // Dropped op: accept only happens when EX is empty or consuming,
          // so the ID/EX register simply empties.
          r_ex_valid   <= 1'b0;
          r_illegal_op <= 1'b1;
        end
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.if_ready    = w_if_ready;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_alu_ctrl = r_ex_alu_ctrl;
  assign bus.ex_in1      = r_ex_in1;
  assign bus.ex_in2      = r_ex_in2;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios for reset, IMMED, register reads, RAW stall with bypass,
// EX back-pressure, illegal opcodes and reset mid-stall, followed by a random
// run checked cycle by cycle against an architectural reference model.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [18:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [4:0] o; logic [3:0] d, a, b;
    o = op[4:0]; d = rd[3:0]; a = rs1[3:0]; b = rs2[3:0];
    return {o, d, a, b, 2'b00};
  endfunction

  function automatic logic [18:0] mk_imm(input int rd, input int imm);
    logic [3:0] d; logic [9:0] v;
    d = rd[3:0]; v = imm[9:0];
    return {5'd12, d, v};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.if_valid = 1'b0; bus.if_instr = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_ready = 1'b1;
  endtask

  task automatic wb_write(input int addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr[3:0]; bus.wb_data = data;
    tick();
    bus.wb_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.if_valid = 1'b1; bus.if_instr = mk_imm(3, 'h155); bus.ex_ready = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; idle();
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got %0h want 0", bus.ex_valid); end
    n_vec++; if (bus.ex_alu_ctrl !== 5'd0) begin n_err++; $display("FAIL reset_ctrl got %0h want 0", bus.ex_alu_ctrl); end
    n_vec++; if (bus.ex_in1 !== 32'd0) begin n_err++; $display("FAIL reset_in1 got %0h want 0", bus.ex_in1); end
    n_vec++; if (bus.ex_in2 !== 32'd0) begin n_err++; $display("FAIL reset_in2 got %0h want 0", bus.ex_in2); end
    n_vec++; if (bus.ex_rd !== 4'd0) begin n_err++; $display("FAIL reset_rd got %0h want 0", bus.ex_rd); end
    n_vec++; if (bus.illegal_op !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %0h want 0", bus.illegal_op); end
    // wb during reset must not have reached R3
    bus.if_valid = 1'b1; bus.if_instr = mk(0, 0, 3, 3);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_in1 !== 32'd0) begin n_err++; $display("FAIL reset_wb_ignored got %0h want 0", bus.ex_in1); end
    wb_write(0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_immed();
    bus.if_valid = 1'b1; bus.if_instr = mk_imm(3, 'h3FF);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL immed_if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL immed_valid got %0h want 1", bus.ex_valid); end
    n_vec++; if (bus.ex_alu_ctrl !== 5'd12) begin n_err++; $display("FAIL immed_ctrl got %0d want 12", bus.ex_alu_ctrl); end
    n_vec++; if (bus.ex_in1 !== 32'd0) begin n_err++; $display("FAIL immed_in1 got %0h want 0", bus.ex_in1); end
    n_vec++; if (bus.ex_in2 !== 32'h3FF) begin n_err++; $display("FAIL immed_in2 got %0h want 3ff", bus.ex_in2); end
    n_vec++; if (bus.ex_rd !== 4'd3) begin n_err++; $display("FAIL immed_rd got %0d want 3", bus.ex_rd); end
    // busy[3] must now block a reader of R3
    bus.if_instr = mk(0, 0, 3, 0);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL immed_busy3 if_ready got %0h want 0", bus.if_ready); end
    tick();
    wb_write(3, 32'd0);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL immed_busy3_clear if_ready got %0h want 1", bus.if_ready); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_add();
    wb_write(1, 32'd5);
    wb_write(2, 32'd7);
    bus.if_valid = 1'b1; bus.if_instr = mk(0, 4, 1, 2);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL add_if_ready got %0h want 1", bus.if_ready); end
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL add_pre_valid got %0h want 0", bus.ex_valid); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0h want 1", bus.ex_valid); end
    n_vec++; if (bus.ex_alu_ctrl !== 5'd0) begin n_err++; $display("FAIL add_ctrl got %0d want 0", bus.ex_alu_ctrl); end
    n_vec++; if (bus.ex_in1 !== 32'd5) begin n_err++; $display("FAIL add_in1 got %0h want 5", bus.ex_in1); end
    n_vec++; if (bus.ex_in2 !== 32'd7) begin n_err++; $display("FAIL add_in2 got %0h want 7", bus.ex_in2); end
    n_vec++; if (bus.ex_rd !== 4'd4) begin n_err++; $display("FAIL add_rd got %0d want 4", bus.ex_rd); end
    wb_write(4, 32'd12);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_raw_hazard();
    bus.if_valid = 1'b1; bus.if_instr = mk_imm(1, 'h11);
    tick();
    bus.if_instr = mk(0, 5, 1, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d if_ready got %0h want 0", i, bus.if_ready); end
      tick();
    end
    bus.wb_en = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 32'h1234;
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL raw_release if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.wb_en = 1'b0; bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL raw_valid got %0h want 1", bus.ex_valid); end
    n_vec++; if (bus.ex_in1 !== 32'h1234) begin n_err++; $display("FAIL raw_bypass_in1 got %0h want 1234", bus.ex_in1); end
    n_vec++; if (bus.ex_in2 !== 32'd7) begin n_err++; $display("FAIL raw_in2 got %0h want 7", bus.ex_in2); end
    n_vec++; if (bus.ex_rd !== 4'd5) begin n_err++; $display("FAIL raw_rd got %0d want 5", bus.ex_rd); end
    wb_write(5, 32'h55);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_pressure();
    bus.if_valid = 1'b1; bus.if_instr = mk_imm(6, 'h2A); bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0; bus.if_instr = mk_imm(7, 'h15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d if_ready got %0h want 0", i, bus.if_ready); end
      tick();
      n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 4'd6 || bus.ex_in2 !== 32'h2A || bus.ex_alu_ctrl !== 5'd12)
        begin n_err++; $display("FAIL bp_stable%0d got v=%0h rd=%0d in2=%0h want v=1 rd=6 in2=2a", i, bus.ex_valid, bus.ex_rd, bus.ex_in2); end
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL bp_release if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 4'd7 || bus.ex_in2 !== 32'h15)
      begin n_err++; $display("FAIL bp_next got v=%0h rd=%0d in2=%0h want v=1 rd=7 in2=15", bus.ex_valid, bus.ex_rd, bus.ex_in2); end
    tick();
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %0h want 0", bus.ex_valid); end
    wb_write(6, 32'd0);
    wb_write(7, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal();
    bus.if_valid = 1'b1; bus.if_instr = mk(20, 9, 0, 0);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL ill_if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.illegal_op !== 1'b1) begin n_err++; $display("FAIL ill_flag got %0h want 1", bus.illegal_op); end
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL ill_no_valid got %0h want 0", bus.ex_valid); end
    // busy[9] untouched: a reader of R9 is accepted at once
    bus.if_valid = 1'b1; bus.if_instr = mk(0, 0, 9, 9);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL ill_no_busy9 if_ready got %0h want 1", bus.if_ready); end
    tick();
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_in1 !== 32'd0) begin n_err++; $display("FAIL ill_next_op got v=%0h in1=%0h want v=1 in1=0", bus.ex_valid, bus.ex_in1); end
    // opcode 13 while EX consumes: ID/EX empties
    bus.if_instr = mk(13, 10, 0, 0);
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL ill13_drop got %0h want 0", bus.ex_valid); end
    bus.if_instr = mk(0, 0, 10, 10);
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL ill13_no_busy10 if_ready got %0h want 1", bus.if_ready); end
    wb_write(0, 32'd0);
    tick(); tick();
    n_vec++; if (bus.illegal_op !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %0h want 1", bus.illegal_op); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstall();
    bus.if_valid = 1'b1; bus.if_instr = mk_imm(5, 1);
    tick();
    bus.ex_ready = 1'b0; bus.if_instr = mk(0, 2, 5, 5);
    tick();
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL rstst_stalled if_ready got %0h want 0", bus.if_ready); end
    rst = 1'b1; bus.if_valid = 1'b0;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL rstst_valid got %0h want 0", bus.ex_valid); end
    n_vec++; if (bus.illegal_op !== 1'b0) begin n_err++; $display("FAIL rstst_illegal got %0h want 0", bus.illegal_op); end
    bus.if_valid = 1'b1; bus.if_instr = mk(0, 0, 5, 5); bus.ex_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL rstst_if_ready got %0h want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    n_vec++; if (bus.ex_valid !== 1'b1 || bus.ex_in1 !== 32'd0 || bus.ex_in2 !== 32'd0)
      begin n_err++; $display("FAIL rstst_r5 got v=%0h in1=%0h in2=%0h want v=1 in1=0 in2=0", bus.ex_valid, bus.ex_in1, bus.ex_in2); end
    wb_write(0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural registers, per-register pending-write flags
  // and the single ID/EX slot.
  logic [31:0] m_regs [16];
  bit          m_busy [16];
  bit          m_exv, m_ill;
  logic [4:0]  m_ctrl;
  logic [31:0] m_in1, m_in2;
  logic [3:0]  m_rd;

  // number of register sources an opcode reads: 2 binary, 1 unary, 0 otherwise
  function automatic int n_sources(input int op);
    if (op inside {0, 1, 2, 3, 6, 7, 8}) return 2;
    if (op inside {4, 5, 9, 10, 11})     return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int r);
    if (bus.wb_en && int'(bus.wb_addr) == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_pending(input int r);
    return m_busy[r] && !(bus.wb_en && int'(bus.wb_addr) == r);
  endfunction

  task automatic test_random();
    int op, rd, s1, s2, a, ns;
    bit exp_ready, acc;
    rst = 1'b1; idle();
    tick();
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    m_exv = 0; m_ill = 0; m_ctrl = '0; m_in1 = '0; m_in2 = '0; m_rd = '0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.if_valid = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(0, 12));
      bus.if_instr = {op[4:0], 14'($urandom)};
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.wb_en = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
        bit found = 0;
        for (int k = 0; k < 16; k++)
          if (!found && m_busy[(a + k) % 16]) begin a = (a + k) % 16; found = 1; end
      end
      bus.wb_addr = a[3:0];
      bus.wb_data = $urandom;

      @(negedge clk);
      rd = int'(bus.if_instr[13:10]); s1 = int'(bus.if_instr[9:6]); s2 = int'(bus.if_instr[5:2]);
      ns = n_sources(op);
      exp_ready = !((ns >= 1 && m_pending(s1)) || (ns == 2 && m_pending(s2))) && (!m_exv || bus.ex_ready);

      n_vec++; if (bus.if_ready !== exp_ready) begin n_err++; $display("FAIL rnd%0d if_ready got %0h want %0h", cyc, bus.if_ready, exp_ready); end
      n_vec++; if (bus.ex_valid !== m_exv) begin n_err++; $display("FAIL rnd%0d ex_valid got %0h want %0h", cyc, bus.ex_valid, m_exv); end
      n_vec++; if (bus.illegal_op !== m_ill) begin n_err++; $display("FAIL rnd%0d illegal got %0h want %0h", cyc, bus.illegal_op, m_ill); end
      if (m_exv) begin
        n_vec++;
        if (bus.ex_alu_ctrl !== m_ctrl || bus.ex_in1 !== m_in1 || bus.ex_in2 !== m_in2 || bus.ex_rd !== m_rd) begin
          n_err++;
          $display("FAIL rnd%0d ex_op got c=%0d a=%0h b=%0h rd=%0d want c=%0d a=%0h b=%0h rd=%0d", cyc,
                   bus.ex_alu_ctrl, bus.ex_in1, bus.ex_in2, bus.ex_rd, m_ctrl, m_in1, m_in2, m_rd);
        end
      end

      // advance the model across the coming edge
      if (rst) begin
        for (int r = 0; r < 16; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
        m_exv = 0; m_ill = 0; m_ctrl = '0; m_in1 = '0; m_in2 = '0; m_rd = '0;
      end else begin
        acc = bus.if_valid && exp_ready;
        if (acc && op <= 12) begin
          m_exv = 1; m_ctrl = op[4:0]; m_rd = rd[3:0];
          m_in1 = (op == 12) ? 32'd0 : m_read(s1);
          m_in2 = (op == 12) ? 32'(bus.if_instr[9:0]) : (ns == 2 ? m_read(s2) : 32'd0);
        end else if (acc) begin
          m_exv = 0; m_ill = 1;
        end else if (bus.ex_ready) begin
          m_exv = 0;
        end
        if (bus.wb_en) begin m_regs[bus.wb_addr] = bus.wb_data; m_busy[bus.wb_addr] = 0; end
        if (acc && op <= 12) m_busy[rd] = 1;
      end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    idle();
    #2;
    test_reset();
    test_immed();
    test_add();
    test_raw_hazard();
    test_back_pressure();
    test_illegal();
    test_reset_midstall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
